// File: rtl/sv_dot_engine_if.sv
// RAM read port and result handshake shared by the dot-product engine and its neighbours.
// master = engine side, slave = RAM / decision-stage side.
interface sv_dot_engine_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned SV_IDX_W   = 3
);
    logic                  sv_cs;
    logic                  sv_we;
    logic                  sv_oe;
    logic [ADDR_WIDTH-1:0] sv_address;
    logic [DATA_WIDTH-1:0] sv_data;

    logic                  res_valid;
    logic                  res_ready;
    logic [DATA_WIDTH-1:0] res_data;
    logic [SV_IDX_W-1:0]   res_sv;
    logic                  res_last;

    modport master (
        output sv_cs, sv_we, sv_oe, sv_address,
        input  sv_data,
        output res_valid, res_data, res_sv, res_last,
        input  res_ready
    );

    modport slave (
        input  sv_cs, sv_we, sv_oe, sv_address,
        output sv_data,
        input  res_valid, res_data, res_sv, res_last,
        output res_ready
    );
endinterface

// File: rtl/sv_dot_engine.sv
// Streams support vectors from the SV RAM, multiplies them against the held feature vector
// and emits one saturated fixed-point dot product per support vector.
module sv_dot_engine #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned NUM_SV     = 8,
    parameter int unsigned NUM_FEAT   = 8,
    parameter int unsigned FRAC_BITS  = 16,
    parameter int unsigned ACC_WIDTH  = 72,
    localparam int unsigned FEAT_IDX_W = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1,
    localparam int unsigned SV_IDX_W   = (NUM_SV > 1) ? $clog2(NUM_SV) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  feat_we,
    input  logic [FEAT_IDX_W-1:0] feat_idx,
    input  logic [DATA_WIDTH-1:0] feat_data,
    output logic                  busy,
    output logic                  done,
    sv_dot_engine_if.master       bus
);
    localparam int unsigned PROD_WIDTH = 2 * DATA_WIDTH;
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, OUT} state_t;

    state_t                        state, state_n;
    logic [FEAT_IDX_W-1:0]         feat_cnt;
    logic [FEAT_IDX_W-1:0]         p1_idx;
    logic [SV_IDX_W-1:0]           sv_cnt;
    logic [ADDR_WIDTH-1:0]         addr_cnt;
    logic                          drain_cnt;
    logic                          p1_v, p2_v;
    logic signed [DATA_WIDTH-1:0]  feat [NUM_FEAT];
    logic signed [PROD_WIDTH-1:0]  prod;
    logic signed [ACC_WIDTH-1:0]   acc;
    logic signed [ACC_WIDTH-1:0]   acc_nx_c;
    logic signed [ACC_WIDTH-1:0]   shifted_c;
    logic [DATA_WIDTH-1:0]         sat_c;
    logic                          fetch_last_c;
    logic                          handshake_c;
    logic                          enter_fetch_c;

    assign fetch_last_c  = (feat_cnt == FEAT_IDX_W'(NUM_FEAT - 1));
    assign handshake_c   = (state == OUT) && bus.res_valid && bus.res_ready;
    assign enter_fetch_c = (state_n == FETCH) && (state != FETCH);
    assign bus.sv_we     = 1'b0;
    assign bus.sv_address = addr_cnt;

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = FETCH;
            FETCH:   if (fetch_last_c) state_n = DRAIN;
            DRAIN:   if (drain_cnt) state_n = OUT;
            OUT:     if (handshake_c) state_n = bus.res_last ? IDLE : FETCH;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Address, feature-index, SV and drain counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_cnt  <= '0;
            feat_cnt  <= '0;
            sv_cnt    <= '0;
            drain_cnt <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                addr_cnt <= '0;
                feat_cnt <= '0;
                sv_cnt   <= '0;
            end
            if (state == FETCH) begin
                addr_cnt <= addr_cnt + ADDR_WIDTH'(1);
                feat_cnt <= fetch_last_c ? '0 : feat_cnt + FEAT_IDX_W'(1);
            end
            drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
            if (handshake_c && !bus.res_last)
                sv_cnt <= sv_cnt + SV_IDX_W'(1);
        end
    end

    // Feature registers are writable only while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_FEAT); i++) feat[i] <= '0;
        end else if (state == IDLE && feat_we && (32'(feat_idx) < NUM_FEAT)) begin
            feat[feat_idx] <= feat_data;
        end
    end

    // Two-stage multiply-accumulate; the RAM data lands one cycle after its address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_v   <= 1'b0;
            p2_v   <= 1'b0;
            p1_idx <= '0;
            prod   <= '0;
            acc    <= '0;
        end else begin
            p1_v   <= (state == FETCH);
            p1_idx <= feat_cnt;
            p2_v   <= p1_v;
            if (p1_v) prod <= $signed(bus.sv_data) * feat[p1_idx];
            if (enter_fetch_c) acc <= '0;
            else               acc <= acc_nx_c;
        end
    end

    assign acc_nx_c = p2_v ? acc + ACC_WIDTH'(prod) : acc;

    // Drop fractional bits (floor) and clamp to the result range
    always_comb begin
        shifted_c = acc_nx_c >>> FRAC_BITS;
        if (shifted_c > SAT_MAX)      sat_c = SAT_MAX[DATA_WIDTH-1:0];
        else if (shifted_c < SAT_MIN) sat_c = SAT_MIN[DATA_WIDTH-1:0];
        else                          sat_c = shifted_c[DATA_WIDTH-1:0];
    end

    // Registered outputs; the result is captured from the final accumulate on DRAIN exit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.sv_cs     <= 1'b0;
            bus.sv_oe     <= 1'b0;
            bus.res_valid <= 1'b0;
            bus.res_data  <= '0;
            bus.res_sv    <= '0;
            bus.res_last  <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            bus.sv_cs <= (state_n == FETCH);
            bus.sv_oe <= (state_n == FETCH);
            busy      <= (state_n != IDLE);
            done      <= handshake_c && bus.res_last;
            if (state == DRAIN && state_n == OUT) begin
                bus.res_valid <= 1'b1;
                bus.res_data  <= sat_c;
                bus.res_sv    <= sv_cnt;
                bus.res_last  <= (sv_cnt == SV_IDX_W'(NUM_SV - 1));
            end else if (handshake_c) begin
                bus.res_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sv_dot_engine.sv
// Directed bench for sv_dot_engine: registered-read RAM model, result checks, timing and control.
module tb_sv_dot_engine;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic        feat_we;
    logic [2:0]  feat_idx;
    logic [31:0] feat_data;
    logic        busy;
    logic        done;

    sv_dot_engine_if #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .SV_IDX_W(3)) bus ();

    sv_dot_engine dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .feat_we   (feat_we),
        .feat_idx  (feat_idx),
        .feat_data (feat_data),
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          t_start = 0;
    int          t_valid = 0;
    logic [31:0] mem [64];
    logic [31:0] exp_res [8];
    logic [5:0]  addr_log [$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Registered-read RAM; junk on the bus whenever it is not being read
    always @(posedge clk) begin
        if (bus.sv_cs && bus.sv_oe && !bus.sv_we) begin
            bus.sv_data <= mem[bus.sv_address];
            addr_log.push_back(bus.sv_address);
        end else begin
            bus.sv_data <= 32'hDEAD_BEEF;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_feats(input logic [31:0] v);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            feat_we = 1'b1; feat_idx = 3'(i); feat_data = v;
        end
        @(negedge clk);
        feat_we = 1'b0;
    endtask

    task automatic set_mem_ramp();
        for (int i = 0; i < 64; i++) mem[i] = 32'((i + 1) << 16);
        for (int s = 0; s < 8; s++) exp_res[s] = 32'((64 * s + 36) << 16);
    endtask

    task automatic set_mem_const(input logic [31:0] v, input logic [31:0] e);
        for (int i = 0; i < 64; i++) mem[i] = v;
        for (int s = 0; s < 8; s++) exp_res[s] = e;
    endtask

    task automatic do_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        t_start = cyc;
    endtask

    task automatic get_result(input string tag, input int s);
        int n = 0;
        while (bus.res_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_timeout"}, 64'(n < 200), 64'd1);
        t_valid = cyc;
        chk({tag, "_data"}, 64'(bus.res_data), 64'(exp_res[s]));
        chk({tag, "_sv"},   64'(bus.res_sv),   64'(s));
        chk({tag, "_last"}, 64'(bus.res_last), 64'(s == 7));
        @(negedge clk);
    endtask

    task automatic run_collect(input string tag, input int first);
        int prev = 0;
        for (int s = first; s < 8; s++) begin
            get_result(tag, s);
            if (s == 0) chk({tag, "_latency"}, 64'(t_valid - t_start), 64'd10);
            else if (s > first) chk({tag, "_period"}, 64'(t_valid - prev), 64'd11);
            prev = t_valid;
        end
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; feat_we = 1'b0; feat_idx = '0; feat_data = '0;
        bus.res_ready = 1'b1;
        bus.sv_data = '0;
        set_mem_ramp();

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_cs",    64'(bus.sv_cs),      64'd0);
        chk("rst_oe",    64'(bus.sv_oe),      64'd0);
        chk("rst_we",    64'(bus.sv_we),      64'd0);
        chk("rst_addr",  64'(bus.sv_address), 64'd0);
        chk("rst_valid", 64'(bus.res_valid),  64'd0);
        chk("rst_data",  64'(bus.res_data),   64'd0);
        chk("rst_sv",    64'(bus.res_sv),     64'd0);
        chk("rst_last",  64'(bus.res_last),   64'd0);
        chk("rst_busy",  64'(busy),           64'd0);
        chk("rst_done",  64'(done),           64'd0);
        rst_n = 1'b1;

        // Basic run and full sweep: features 1.0, SV words 1.0..64.0
        set_feats(32'h0001_0000);
        addr_log.delete();
        do_start();
        chk("fetch_cs",   64'(bus.sv_cs),      64'd1);
        chk("fetch_oe",   64'(bus.sv_oe),      64'd1);
        chk("fetch_we",   64'(bus.sv_we),      64'd0);
        chk("fetch_addr", 64'(bus.sv_address), 64'd0);
        chk("fetch_busy", 64'(busy),           64'd1);
        repeat (9) @(negedge clk);
        chk("early_valid", 64'(bus.res_valid), 64'd0);
        chk("drain_cs",    64'(bus.sv_cs),     64'd0);
        run_collect("sweep", 0);
        @(negedge clk);
        chk("done_pulse", 64'(done), 64'd0);
        chk("sweep_count", 64'(addr_log.size()), 64'd64);
        for (int i = 0; i < 64 && i < addr_log.size(); i++)
            chk("sweep_addr", 64'(addr_log[i]), 64'(i));

        // Positive and negative saturation
        set_feats(32'h7FFF_0000);
        set_mem_const(32'h7FFF_0000, 32'h7FFF_FFFF);
        do_start();
        run_collect("sat_pos", 0);
        set_mem_const(32'h8001_0000, 32'h8000_0000);
        do_start();
        run_collect("sat_neg", 0);

        // Backpressure on SV 0
        set_feats(32'h0001_0000);
        set_mem_ramp();
        bus.res_ready = 1'b0;
        do_start();
        begin
            int n = 0;
            while (bus.res_valid !== 1'b1 && n < 200) begin
                @(negedge clk);
                n++;
            end
            chk("bp_timeout", 64'(n < 200), 64'd1);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", 64'(bus.res_valid), 64'd1);
            chk("bp_data",  64'(bus.res_data),  64'(exp_res[0]));
            chk("bp_sv",    64'(bus.res_sv),    64'd0);
            chk("bp_cs",    64'(bus.sv_cs),     64'd0);
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        chk("bp_refetch_cs",   64'(bus.sv_cs),      64'd1);
        chk("bp_refetch_addr", 64'(bus.sv_address), 64'd8);
        chk("bp_refetch_vld",  64'(bus.res_valid),  64'd0);
        run_collect("bp", 1);

        // start / feat_we while busy are ignored
        do_start();
        repeat (3) @(negedge clk);
        start = 1'b1; feat_we = 1'b1; feat_idx = 3'd0; feat_data = 32'h0005_0000;
        @(negedge clk);
        start = 1'b0; feat_we = 1'b0;
        chk("ign_addr", 64'(bus.sv_address), 64'd4);
        run_collect("ign_run1", 0);
        do_start();
        run_collect("ign_run2", 0);

        // Asynchronous reset during FETCH of SV 3
        do_start();
        for (int s = 0; s < 3; s++) get_result("rst_pre", s);
        repeat (2) @(negedge clk);
        chk("pre_rst_cs",   64'(bus.sv_cs),      64'd1);
        chk("pre_rst_addr", 64'(bus.sv_address), 64'd26);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_cs",    64'(bus.sv_cs),     64'd0);
        chk("mid_rst_valid", 64'(bus.res_valid), 64'd0);
        chk("mid_rst_busy",  64'(busy),          64'd0);
        chk("mid_rst_addr",  64'(bus.sv_address), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        chk("post_rst_valid", 64'(bus.res_valid), 64'd0);
        chk("post_rst_cs",    64'(bus.sv_cs),     64'd0);
        chk("post_rst_busy",  64'(busy),          64'd0);
        set_feats(32'h0001_0000);
        do_start();
        run_collect("after_rst", 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
